// File: rtl/vmem_wr_queue_pkg.sv
// Shared configuration for the video-memory write queue.
// Holds the default sizing constants used by vmem_wr_queue and the
// memory-map constant for the video-memory region (0x2xxxxxxx), plus a
// helper that classifies a CPU address as a video-memory access.
package vmem_wr_queue_pkg;

  localparam int unsigned NCORES_DEF      = 2;
  localparam int unsigned VMEM_ADDRW_DEF  = 16;
  localparam int unsigned VMEM_WDATAW_DEF = 3;
  localparam int unsigned FIFO_DEPTH_DEF  = 4;

  // Video memory occupies the 0x2xxxxxxx window of the CPU address map.
  localparam logic [31:0] VMEM_BASE        = 32'h2000_0000;
  localparam logic [31:0] VMEM_REGION_MASK = 32'hF000_0000;

  function automatic logic is_vmem_addr(input logic [31:0] cpu_addr);
    return (cpu_addr & VMEM_REGION_MASK) == VMEM_BASE;
  endfunction

endpackage

// File: rtl/wrq_fifo.sv
// Synchronous per-core write FIFO.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   push, din    enqueue request and entry; ignored while full
//   pop          dequeue request; ignored while empty
//   dout         head entry (combinational read of the head slot)
//   full, empty  status derived from count
//   count        occupancy, 0..DEPTH
// DEPTH must be a power of two (pointers wrap by natural overflow).
// Storage is not reset; only pointers and count are.
module wrq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the count at the start of the cycle, so a pop in
  // the same cycle never lets a push into a full FIFO.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vmem_wr_queue.sv
// Merges pixel writes from NCORES CPU cores into the single write port of
// the video RAM. Each core has a private wrq_fifo; one non-empty FIFO is
// popped per cycle and its head is registered onto the vmem_* outputs.
// Ports:
//   clk_i, rst_i     clock (rising edge), asynchronous active-high reset
//   we_packed_i      per-core write request
//   addr_packed_i    per-core address, core i at [VMEM_ADDRW*(i+1)-1 : VMEM_ADDRW*i]
//   wdata_packed_i   per-core pixel data, same slicing
//   stall_packed_o   per-core stall (request present while that FIFO is full)
//   vmem_we_o        registered write enable to the video RAM
//   vmem_addr_o      registered write address (holds when no write)
//   vmem_wdata_o     registered write data (holds when no write)
//   idle_o           all FIFOs empty and no write on the output registers
// Build option: define VMEM_WRQ_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no round-robin pointer); default is round-robin.
`ifndef NCORES
`define NCORES NCORES_DEF
`endif
`ifndef VMEM_ADDRW
`define VMEM_ADDRW VMEM_ADDRW_DEF
`endif

module vmem_wr_queue
  import vmem_wr_queue_pkg::*;
#(
  parameter int unsigned NCORES      = `NCORES,
  parameter int unsigned VMEM_ADDRW  = `VMEM_ADDRW,
  parameter int unsigned VMEM_WDATAW = VMEM_WDATAW_DEF,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NCORES-1:0]             we_packed_i,
  input  logic [VMEM_ADDRW*NCORES-1:0]  addr_packed_i,
  input  logic [VMEM_WDATAW*NCORES-1:0] wdata_packed_i,
  output logic [NCORES-1:0]             stall_packed_o,
  output logic                          vmem_we_o,
  output logic [VMEM_ADDRW-1:0]         vmem_addr_o,
  output logic [VMEM_WDATAW-1:0]        vmem_wdata_o,
  output logic                          idle_o
);

  localparam int unsigned IDXW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW   = VMEM_ADDRW + VMEM_WDATAW;

  logic [NCORES-1:0] full;
  logic [NCORES-1:0] empty;
  logic [NCORES-1:0] pop;
  logic [NCORES-1:0] cnt_zero;
  logic [EW-1:0]     head [NCORES];
  logic              grant_valid;
  logic [IDXW-1:0]   grant_idx;
  logic [IDXW-1:0]   cand;

  for (genvar i = 0; i < NCORES; i++) begin : g_fifo
    logic [CNTW-1:0] count;

    wrq_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (we_packed_i[i]),
      .pop   (pop[i]),
      .din   ({addr_packed_i[VMEM_ADDRW*i +: VMEM_ADDRW],
               wdata_packed_i[VMEM_WDATAW*i +: VMEM_WDATAW]}),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (count)
    );

    assign cnt_zero[i] = (count == '0);
    assign pop[i]      = grant_valid && (grant_idx == IDXW'(i));
  end

  assign stall_packed_o = we_packed_i & full;
  assign idle_o         = (&cnt_zero) & ~vmem_we_o;

`ifdef VMEM_WRQ_FIXED_PRIO_EN
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NCORES; k++) begin
      cand = IDXW'(k);
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end
`else
  logic [IDXW-1:0] rr_ptr;

  // Scan cores starting at rr_ptr; first non-empty one wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NCORES; k++) begin
      cand = IDXW'((32'(rr_ptr) + k) % NCORES);
      if (!grant_valid && !empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (32'(grant_idx) == NCORES - 1) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vmem_we_o    <= 1'b0;
      vmem_addr_o  <= '0;
      vmem_wdata_o <= '0;
    end else begin
      vmem_we_o <= grant_valid;
      if (grant_valid) {vmem_addr_o, vmem_wdata_o} <= head[grant_idx];
    end
  end

endmodule

// File: tb/tb_vmem_wr_queue.sv
// Directed self-checking bench for vmem_wr_queue (NCORES=2, 16-bit
// addresses, 3-bit data, depth 4, round-robin build).
module tb_vmem_wr_queue;

  localparam int unsigned NC    = 2;
  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 3;
  localparam int unsigned DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     we;
  logic [AW*NC-1:0]  addr;
  logic [DW*NC-1:0]  wdata;
  logic [NC-1:0]     stall;
  logic              vmem_we;
  logic [AW-1:0]     vmem_addr;
  logic [DW-1:0]     vmem_wdata;
  logic              idle;

  int tests = 0;
  int fails = 0;
  int s0, s1, cyc;
  logic acc0, acc1;
  logic [31:0] expv, obsv;
  logic [AW+DW-1:0] outq [$];

  always #5 clk = ~clk;

  vmem_wr_queue #(
    .NCORES      (NC),
    .VMEM_ADDRW  (AW),
    .VMEM_WDATAW (DW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .we_packed_i    (we),
    .addr_packed_i  (addr),
    .wdata_packed_i (wdata),
    .stall_packed_o (stall),
    .vmem_we_o      (vmem_we),
    .vmem_addr_o    (vmem_addr),
    .vmem_wdata_o   (vmem_wdata),
    .idle_o         (idle)
  );

  // Record every emitted write as {data, addr}.
  always @(negedge clk) begin
    if (rst === 1'b0 && vmem_we === 1'b1) outq.push_back({vmem_wdata, vmem_addr});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[c]             = w;
    addr[AW*c +: AW]  = a;
    wdata[DW*c +: DW] = d;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(idle), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion expected finish before timeout");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    rst = 1'b1; we = '0; addr = '0; wdata = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_we",    32'(vmem_we),    32'd0);
    chk("rst_addr",  32'(vmem_addr),  32'd0);
    chk("rst_wdata", 32'(vmem_wdata), 32'd0);
    chk("rst_stall", 32'(stall),      32'd0);
    chk("rst_idle",  32'(idle),       32'd1);
    rst = 1'b0;
    tick();
    chk("post_rst_idle",  32'(idle),  32'd1);
    chk("post_rst_stall", 32'(stall), 32'd0);

    // Single write: accepted in cycle N, emitted in N+2 only
    set_core(0, 1'b1, 16'h0010, 3'b101);
    #1;
    chk("single_stall", 32'(stall), 32'd0);
    tick();
    set_core(0, 1'b0, '0, '0);
    #1;
    chk("single_n1_we",   32'(vmem_we), 32'd0);
    chk("single_n1_idle", 32'(idle),    32'd0);
    tick();
    chk("single_n2_we",    32'(vmem_we),    32'd1);
    chk("single_n2_addr",  32'(vmem_addr),  32'h0010);
    chk("single_n2_wdata", 32'(vmem_wdata), 32'd5);
    chk("single_n2_idle",  32'(idle),       32'd0);
    tick();
    chk("single_n3_we",    32'(vmem_we),    32'd0);
    chk("single_n3_idle",  32'(idle),       32'd1);
    chk("single_n3_addr",  32'(vmem_addr),  32'h0010);
    chk("single_n3_wdata", 32'(vmem_wdata), 32'd5);
    outq.delete();

    // Flood: core0 sends 0x100.. (10 writes), core1 sends 1..8; both hold
    // their request while stalled. Last grant was core0, so core1 goes first.
    s0 = 0; s1 = 0; cyc = 0;
    while ((s0 < 10 || s1 < 8) && cyc < 100) begin
      set_core(0, s0 < 10, AW'(32'h100 + s0), 3'd2);
      set_core(1, s1 < 8,  AW'(1 + s1),       3'd6);
      #1;
      if (cyc <= 6) chk($sformatf("stall0_c%0d", cyc), 32'(stall[0]), 32'(cyc == 6));
      if (cyc <= 7) chk($sformatf("stall1_c%0d", cyc), 32'(stall[1]), 32'(cyc == 7));
      acc0 = we[0] & ~stall[0];
      acc1 = we[1] & ~stall[1];
      tick();
      if (acc0) s0++;
      if (acc1) s1++;
      cyc++;
    end
    set_core(0, 1'b0, '0, '0);
    set_core(1, 1'b0, '0, '0);
    chk("flood_acc0", 32'(s0), 32'd10);
    chk("flood_acc1", 32'(s1), 32'd8);
    drain("flood_idle");
    chk("flood_count", 32'(outq.size()), 32'd18);
    for (int j = 0; j < 18; j++) begin
      if (j < 16) expv = (j % 2 == 0) ? {13'd0, 3'd6, 16'(1 + j / 2)}
                                      : {13'd0, 3'd2, 16'(32'h100 + j / 2)};
      else        expv = {13'd0, 3'd2, 16'(32'h100 + j - 8)};
      obsv = (j < outq.size()) ? 32'(outq[j]) : 32'hFFFF_FFFF;
      chk($sformatf("flood_out%0d", j), obsv, expv);
    end
    outq.delete();

    // Same-cycle push/pop on a one-entry FIFO
    set_core(0, 1'b1, 16'h00A0, 3'd1);
    tick();
    set_core(0, 1'b1, 16'h00B0, 3'd3);
    #1;
    chk("pp_stall", 32'(stall), 32'd0);
    tick();
    set_core(0, 1'b0, '0, '0);
    #1;
    chk("pp_first_we",   32'(vmem_we),   32'd1);
    chk("pp_first_addr", 32'(vmem_addr), 32'h00A0);
    tick();
    chk("pp_second_we",    32'(vmem_we),    32'd1);
    chk("pp_second_addr",  32'(vmem_addr),  32'h00B0);
    chk("pp_second_wdata", 32'(vmem_wdata), 32'd3);
    tick();
    chk("pp_end_we",   32'(vmem_we), 32'd0);
    chk("pp_end_idle", 32'(idle),    32'd1);
    outq.delete();

    // Reset with three entries queued and a write on the output registers
    set_core(0, 1'b1, 16'h0300, 3'd1);
    set_core(1, 1'b1, 16'h0400, 3'd2);
    tick();
    set_core(0, 1'b1, 16'h0301, 3'd1);
    set_core(1, 1'b1, 16'h0401, 3'd2);
    tick();
    set_core(0, 1'b0, '0, '0);
    set_core(1, 1'b0, '0, '0);
    chk("mid_pre_we", 32'(vmem_we), 32'd1);
    rst = 1'b1;
    outq.delete();
    #1;
    chk("mid_rst_we",   32'(vmem_we),   32'd0);
    chk("mid_rst_addr", 32'(vmem_addr), 32'd0);
    chk("mid_rst_idle", 32'(idle),      32'd1);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("mid_rel_we", 32'(vmem_we), 32'd0);
    repeat (10) tick();
    chk("mid_none_emitted", 32'(outq.size()), 32'd0);
    chk("mid_end_idle",     32'(idle),        32'd1);
    chk("mid_end_we",       32'(vmem_we),     32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vmem_wr_queue.md
VMEM_WR_QUEUE -- requirements
Module: vmem_wr_queue

Interface
REQ-001 SHALL have parameter NCORES, default `NCORES: number of CPU write sources.
REQ-002 SHALL have parameter VMEM_ADDRW, default `VMEM_ADDRW: video-memory address width.
REQ-003 SHALL have parameter VMEM_WDATAW, default 3: pixel write width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: per-core entries, power of two, at least 2.
REQ-005 SHALL have ports, one per line:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- we_packed_i  in  NCORES  per-core write request.
- addr_packed_i  in  VMEM_ADDRW*NCORES  per-core address; core i occupies slice [VMEM_ADDRW*(i+1)-1 : VMEM_ADDRW*i].
- wdata_packed_i  in  VMEM_WDATAW*NCORES  per-core pixel data; same slicing.
- stall_packed_o  out  NCORES  per-core stall.
- vmem_we_o  out  1  registered write enable to the video RAM write port.
- vmem_addr_o  out  VMEM_ADDRW  registered write address.
- vmem_wdata_o  out  VMEM_WDATAW  registered write data.
- idle_o  out  1  high when all queues are empty and no write is pending on the output registers.

Function
REQ-006 SHALL give each core a private FIFO of FIFO_DEPTH {addr, wdata} entries.
REQ-007 SHALL enqueue core i's request at a clock edge when we_packed_i[i]=1 and FIFO i is not full at the start of that cycle.
REQ-008 SHALL drive stall_packed_o[i] = we_packed_i[i] & full_i, combinationally. Full means count == FIFO_DEPTH. A pop in the same cycle SHALL NOT unblock the push.
REQ-009 SHALL keep each core's requests in arrival order; a requester that holds its inputs while stalled is enqueued exactly once.
REQ-010 SHALL select at most one non-empty FIFO per cycle, pop its head, and load the head into vmem_addr_o/vmem_wdata_o with vmem_we_o=1 at that edge.
REQ-011 SHALL deassert vmem_we_o in any cycle that follows an edge with no pop. vmem_addr_o and vmem_wdata_o SHALL hold their last values.
REQ-012 Latency: a write accepted in cycle N, with no competition, SHALL appear with vmem_we_o=1 in cycle N+2.
REQ-013 Throughput: sustained rate SHALL be one write per cycle across all cores.
REQ-014 Arbitration (default): round-robin. After granting core g, priority order SHALL start at (g+1) mod NCORES. With a single requesting core, that core SHALL be granted every cycle.
REQ-015 SHALL handle push and pop on the same FIFO in the same cycle with count unchanged. This includes a FIFO holding one entry, and it SHALL preserve order.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Count width SHALL be clog2(FIFO_DEPTH)+1.
REQ-017 SHALL assert idle_o combinationally when all counts are 0 and vmem_we_o=0.

Reset
REQ-018 While rst_i=1 SHALL hold: all FIFO pointers and counts 0, vmem_we_o=0, vmem_addr_o=0, vmem_wdata_o=0, round-robin pointer at core 0.
REQ-019 After reset: stall_packed_o=0 and idle_o=1.
REQ-020 Reset mid-operation SHALL discard all queued writes. No vmem_we_o pulse SHALL occur on or after the asserting edge.
REQ-021 FIFO storage arrays are not reset.

Configuration
REQ-022 Macro VMEM_WRQ_FIXED_PRIO_EN:
- Defined: fixed priority, lowest-index non-empty FIFO wins, and the round-robin pointer is not implemented.
- Undefined: round-robin per REQ-014.

Structure
REQ-023 VMEM_WDATAW default, FIFO_DEPTH default and the memory-map constant for video memory (0x2xxxxxxx) SHALL live in the shared config header/package. No local duplicates.
REQ-024 SHALL instantiate NCORES copies of one sub-module, wrq_fifo: a synchronous FIFO with push, pop, full, empty and count. Arbitration and output registers stay in vmem_wr_queue.

Verification
REQ-025 Single write, NCORES=2, DEPTH=4: core0 writes addr 0x0010, data 3'b101 in cycle 5 -> vmem_we_o=1, addr 0x0010, data 5 in cycle 7 only; idle_o=1 from cycle 8.
REQ-026 Full/stall: core1 holds we high for 6 consecutive cycles with addresses 1..6, no pops possible (core0 flooding) -> stall_packed_o[1]=1 once four entries are queued; all six addresses eventually emitted in order 1..6.
REQ-027 Round-robin: both cores write continuously, core0 addresses 0x100+k, core1 addresses 0x200+k -> vmem output alternates 0x100, 0x200, 0x101, 0x201, ...; with VMEM_WRQ_FIXED_PRIO_EN, all core0 writes drain before any core1 write while core0 stays non-empty.
REQ-028 Same-cycle push/pop: a one-entry FIFO receives a new write in the cycle its head is popped -> count stays 1, next output is the new write.
REQ-029 Reset mid-operation: rst_i pulsed with 3 entries queued -> vmem_we_o=0 immediately and thereafter, idle_o=1, no queued write ever emitted.
